// File: rtl/bus_trace_pkg.sv
// Shared encodings and entry layout for the bus trace capture block.
// Entries are packed {ctrl, addr, data, ts}, MSB first.
package bus_trace_pkg;

  typedef enum logic [1:0] {
    CTRL_NONE  = 2'b00,
    CTRL_READ  = 2'b01,
    CTRL_WRITE = 2'b10,
    CTRL_RSVD  = 2'b11
  } bus_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_TRIG  = 2'b10,
    ST_DONE  = 2'b11
  } trace_state_e;

  function automatic int ts_lsb();
    return 0;
  endfunction

  function automatic int data_lsb(int tsw);
    return tsw;
  endfunction

  function automatic int addr_lsb(int dw, int tsw);
    return dw + tsw;
  endfunction

  function automatic int ctrl_lsb(int aw, int dw, int tsw);
    return aw + dw + tsw;
  endfunction

endpackage

// File: rtl/bus_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 50
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [W-1:0]               wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [W-1:0]               rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_trace.sv
// Passive bus snooper: circular capture buffer with address/ctrl trigger,
// post-trigger window and an oldest-first valid/ready drain port.
//
// state     | meaning
// ST_IDLE   | no capture, waiting for arm
// ST_ARMED  | capturing into circular buffer, watching for trigger
// ST_TRIG   | trigger stored, counting post-trigger entries
// ST_DONE   | window frozen, draining oldest-first
module bus_trace
  import bus_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int TSW   = 16,
  parameter int POST  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AW-1:0]             bus_addr,
  input  logic [1:0]                bus_ctrl,
  input  logic [DW-1:0]             bus_data,
  input  logic                      arm,
  input  logic [AW-1:0]             trig_addr,
  input  logic [AW-1:0]             trig_mask,
  input  logic [1:0]                trig_ctrl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2+AW+DW+TSW-1:0]    out_data,
  output logic [1:0]                state,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW       = $clog2(DEPTH);
  localparam int EW       = 2 + AW + DW + TSW;
  localparam int TS_LSB   = ts_lsb();
  localparam int DATA_LSB = data_lsb(TSW);
  localparam int ADDR_LSB = addr_lsb(DW, TSW);
  localparam int CTRL_LSB = ctrl_lsb(AW, DW, TSW);

  trace_state_e    state_q, state_d;
  logic [TSW-1:0]  ts_q;
  logic [1:0]      prev_ctrl_q;
  logic [AW-1:0]   prev_addr_q;
  logic            pend_q, pend_match_q;
  logic [1:0]      pend_ctrl_q;
  logic [AW-1:0]   pend_addr_q;
  logic [DW-1:0]   pend_data_q;
  logic [TSW-1:0]  pend_ts_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, post_q;
  logic [PW:0]     count_q;
  logic            start, match, arm_ok, capturing, wr_en, trig_hit, pop;
  logic [EW-1:0]   wr_entry, rd_entry;

  assign start     = (bus_ctrl == CTRL_READ || bus_ctrl == CTRL_WRITE) &&
                     (bus_ctrl != prev_ctrl_q || bus_addr != prev_addr_q);
  assign match     = (((bus_addr ^ trig_addr) & trig_mask) == '0) &&
                     (trig_ctrl == CTRL_NONE || trig_ctrl == bus_ctrl);
  assign arm_ok    = arm && (state_q == ST_IDLE || state_q == ST_DONE);
  assign capturing = (state_q == ST_ARMED || state_q == ST_TRIG);
  assign wr_en     = pend_q && capturing;
  assign trig_hit  = wr_en && pend_match_q && state_q == ST_ARMED;
  assign out_valid = (state_q == ST_DONE) && (count_q != '0);
  // arm takes priority over a simultaneous pop
  assign pop       = out_valid && out_ready && !arm_ok;
  assign out_data  = out_valid ? rd_entry : '0;
  assign state     = state_q;
  assign count     = count_q;

  // read data arrives the cycle after the start, write data is held from it
  always_comb begin
    wr_entry = '0;
    wr_entry[CTRL_LSB +: 2]  = pend_ctrl_q;
    wr_entry[ADDR_LSB +: AW] = pend_addr_q;
    wr_entry[DATA_LSB +: DW] = (pend_ctrl_q == CTRL_READ) ? bus_data : pend_data_q;
    wr_entry[TS_LSB +: TSW]  = pend_ts_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arm) state_d = ST_ARMED;
      ST_ARMED: if (trig_hit) state_d = (POST == 0) ? ST_DONE : ST_TRIG;
      ST_TRIG:  if (wr_en && post_q == PW'(1)) state_d = ST_DONE;
      ST_DONE:  if (arm) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q         <= '0;
      prev_ctrl_q  <= '0;
      prev_addr_q  <= '0;
      pend_q       <= 1'b0;
      pend_match_q <= 1'b0;
      pend_ctrl_q  <= '0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_ts_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      post_q       <= '0;
    end else begin
      ts_q        <= ts_q + TSW'(1);
      prev_ctrl_q <= bus_ctrl;
      prev_addr_q <= bus_addr;
      pend_q      <= start && capturing;
      if (start) begin
        pend_match_q <= match;
        pend_ctrl_q  <= bus_ctrl;
        pend_addr_q  <= bus_addr;
        pend_data_q  <= bus_data;
        pend_ts_q    <= ts_q;
      end

      if (arm_ok) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        if (count_q == (PW+1)'(DEPTH)) rd_ptr_q <= rd_ptr_q + PW'(1);
        else                           count_q  <= count_q + (PW+1)'(1);
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q  <= count_q - (PW+1)'(1);
      end

      if (trig_hit)                         post_q <= PW'(POST);
      else if (wr_en && state_q == ST_TRIG) post_q <= post_q - PW'(1);
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

endmodule

// File: tb/tb_bus_trace.sv
// Self-checking bench for bus_trace: queue-based reference model compared
// every cycle, plus directed windows with literal expectations.
module tb_bus_trace;

  localparam int DEPTH = 16;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int TSW   = 16;
  localparam int POST  = 8;
  localparam int EW    = 2 + AW + DW + TSW;

  logic            clk, reset;
  logic [AW-1:0]   bus_addr;
  logic [1:0]      bus_ctrl;
  logic [DW-1:0]   bus_data;
  logic            arm;
  logic [AW-1:0]   trig_addr, trig_mask;
  logic [1:0]      trig_ctrl;
  logic            out_valid, out_ready;
  logic [EW-1:0]   out_data;
  logic [1:0]      state;
  logic [4:0]      count;

  bus_trace #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TSW(TSW), .POST(POST)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_ctrl(bus_ctrl),
    .bus_data(bus_data), .arm(arm), .trig_addr(trig_addr), .trig_mask(trig_mask),
    .trig_ctrl(trig_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .state(state), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] f_ctrl(input logic [EW-1:0] e);
    return e[EW-1 -: 2];
  endfunction
  function automatic logic [AW-1:0] f_addr(input logic [EW-1:0] e);
    return e[TSW+DW +: AW];
  endfunction
  function automatic logic [DW-1:0] f_data(input logic [EW-1:0] e);
    return e[TSW +: DW];
  endfunction
  function automatic logic [TSW-1:0] f_ts(input logic [EW-1:0] e);
    return e[0 +: TSW];
  endfunction

  // Reference model: the buffer is a queue of whole entries, trimmed to DEPTH.
  logic [EW-1:0]  mq[$];
  int             m_st = 0;
  int             m_post = 0;
  int             st0;
  bit             arm_ok;
  logic [TSW-1:0] m_ts = '0;
  logic [1:0]     m_pc = '0;
  logic [AW-1:0]  m_pa = '0;
  bit             p_v = 0, p_m = 0;
  logic [1:0]     p_c = '0;
  logic [AW-1:0]  p_a = '0;
  logic [DW-1:0]  p_d = '0;
  logic [TSW-1:0] p_t = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_st = 0; m_post = 0; m_ts = '0; m_pc = '0; m_pa = '0; p_v = 0;
    end else begin
      st0    = m_st;
      arm_ok = arm && (st0 == 0 || st0 == 3);
      if (p_v && (st0 == 1 || st0 == 2)) begin
        mq.push_back({p_c, p_a, (p_c == 2'b01) ? bus_data : p_d, p_t});
        if (mq.size() > DEPTH) void'(mq.pop_front());
        if (st0 == 1 && p_m) begin
          m_st   = (POST == 0) ? 3 : 2;
          m_post = POST;
        end else if (st0 == 2) begin
          m_post--;
          if (m_post == 0) m_st = 3;
        end
      end
      if (st0 == 3 && mq.size() != 0 && out_ready && !arm_ok) void'(mq.pop_front());
      if (arm_ok) begin
        mq.delete();
        m_st = 1;
      end
      p_v = (bus_ctrl == 2'b01 || bus_ctrl == 2'b10) &&
            (bus_ctrl != m_pc || bus_addr != m_pa) && (st0 == 1 || st0 == 2);
      p_m = (((bus_addr ^ trig_addr) & trig_mask) == '0) &&
            (trig_ctrl == 2'b00 || trig_ctrl == bus_ctrl);
      p_c = bus_ctrl; p_a = bus_addr; p_d = bus_data; p_t = m_ts;
      m_pc = bus_ctrl; m_pa = bus_addr;
      m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("state", state, 64'(m_st));
    chk("count", count, 64'(mq.size()));
    chk("out_valid", out_valid, 64'(m_st == 3 && mq.size() != 0));
    chk("out_data", out_data, (m_st == 3 && mq.size() != 0) ? 64'(mq[0]) : 64'd0);
  end

  logic [EW-1:0] got[$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bus(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_ctrl = c; bus_addr = a; bus_data = d;
    step();
  endtask

  task automatic idle(input int n);
    bus_ctrl = 2'b00;
    repeat (n) step();
  endtask

  task automatic do_arm(input logic [AW-1:0] ta, input logic [AW-1:0] tm, input logic [1:0] tc);
    trig_addr = ta; trig_mask = tm; trig_ctrl = tc;
    bus_ctrl = 2'b00; arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic finish_window();
    bus(2'b10, 16'h8000, 16'hBEEF);
    for (int j = 1; j <= POST; j++) bus(2'b10, 16'h0200 + AW'(j), DW'($urandom));
    idle(2);
    chk("window_done", state, 64'd3);
  endtask

  task automatic drain();
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!out_valid) break;
      got.push_back(out_data);
      step();
    end
    out_ready = 1'b0;
    chk("drain_bounded", out_valid, 64'd0);
  endtask

  initial begin
    int r;
    int exp_c;
    logic [EW-1:0] d0;

    reset = 1'b0; arm = 1'b0; out_ready = 1'b0;
    bus_ctrl = '0; bus_addr = '0; bus_data = '0;
    trig_addr = '0; trig_mask = '0; trig_ctrl = '0;

    // reset held with bus activity
    for (int i = 0; i < 4; i++) bus(2'b10, 16'h1230 + AW'(i), 16'h5555);
    chk("rst_state", state, 64'd0);
    chk("rst_count", count, 64'd0);
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_data", out_data, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) bus(2'b10, 16'h0040 + AW'(i), 16'h6666);
    idle(2);
    chk("noarm_count", count, 64'd0);
    chk("noarm_state", state, 64'd0);

    // basic window
    do_arm(16'h8000, 16'hFFFF, 2'b00);
    for (int i = 1; i <= 4; i++) bus(2'b10, AW'(i), 16'h1000 + DW'(i));
    bus(2'b10, 16'h8000, 16'hBEEF);
    for (int j = 1; j <= 8; j++) bus(2'b10, 16'h0010 + AW'(j), 16'h2000 + DW'(j));
    idle(2);
    chk("basic_state", state, 64'd3);
    chk("basic_count", count, 64'd13);
    drain();
    chk("basic_size", 64'(got.size()), 64'd13);
    if (got.size() == 13) begin
      chk("basic_first_addr", f_addr(got[0]), 64'h0001);
      chk("basic_first_data", f_data(got[0]), 64'h1001);
      chk("basic_trig_addr", f_addr(got[4]), 64'h8000);
      chk("basic_trig_ctrl", f_ctrl(got[4]), 64'h2);
      chk("basic_last_addr", f_addr(got[12]), 64'h0018);
      for (int i = 1; i < 13; i++)
        chk("basic_ts_step", 64'(TSW'(f_ts(got[i]) - f_ts(got[i-1]))), 64'd1);
    end

    // pre-trigger wrap
    do_arm(16'h8000, 16'hFFFF, 2'b00);
    for (int i = 1; i <= 30; i++) bus(2'b10, 16'h0100 + AW'(i), DW'($urandom));
    finish_window();
    chk("wrap_count", count, 64'd16);
    drain();
    chk("wrap_size", 64'(got.size()), 64'd16);
    if (got.size() == 16) begin
      chk("wrap_first", f_addr(got[0]), 64'h0118);
      chk("wrap_last", f_addr(got[15]), 64'h0208);
    end

    // read latency and write data timing
    do_arm(16'h8000, 16'hFFFF, 2'b00);
    bus(2'b01, 16'h0010, 16'h1111);
    bus(2'b00, 16'h0010, 16'hABCD);
    bus(2'b10, 16'h0020, 16'h5A5A);
    bus(2'b00, 16'h0020, 16'hFFFF);
    finish_window();
    drain();
    chk("lat_size", 64'(got.size()), 64'd11);
    if (got.size() >= 2) begin
      chk("rd_entry", 64'(got[0][EW-1:TSW]), {14'd0, 2'b01, 16'h0010, 16'hABCD});
      chk("wr_entry", 64'(got[1][EW-1:TSW]), {14'd0, 2'b10, 16'h0020, 16'h5A5A});
    end

    // start filtering, arm ignored while armed
    do_arm(16'h8000, 16'hFFFF, 2'b00);
    repeat (3) bus(2'b10, 16'h0004, 16'h4444);
    repeat (2) bus(2'b11, 16'h0004, 16'h4444);
    idle(2);
    chk("filt_one", count, 64'd1);
    do_arm(16'h8000, 16'hFFFF, 2'b00);
    chk("arm_ignored_state", state, 64'd1);
    chk("arm_ignored_count", count, 64'd1);
    bus(2'b10, 16'h0030, 16'h3030);
    bus(2'b01, 16'h0030, 16'h3131);
    idle(2);
    chk("filt_three", count, 64'd3);
    finish_window();
    drain();
    chk("filt_size", 64'(got.size()), 64'd12);

    // backpressure, handshakes, arm vs pop, reset mid-drain
    do_arm(16'h8000, 16'hFFFF, 2'b00);
    for (int i = 1; i <= 3; i++) bus(2'b10, 16'h0050 + AW'(i), DW'($urandom));
    finish_window();
    chk("bp_count", count, 64'd12);
    d0 = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_stable", out_data, 64'(d0));
      chk("bp_valid", out_valid, 64'd1);
    end
    exp_c = 12;
    for (int k = 0; k < 6; k++) begin
      out_ready = (k % 2 == 0);
      step();
      if (k % 2 == 0) exp_c--;
      chk("hs_count", count, 64'(exp_c));
    end
    out_ready = 1'b1;
    do_arm(16'h8000, 16'hFFFF, 2'b00);
    out_ready = 1'b0;
    chk("armpop_state", state, 64'd1);
    chk("armpop_count", count, 64'd0);
    finish_window();
    out_ready = 1'b1;
    step();
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 64'd0);
    chk("rst_mid_count", count, 64'd0);
    chk("rst_mid_state", state, 64'd0);
    out_ready = 1'b0;
    step();
    reset = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 4 != 0) begin
        r = int'($urandom % 8);
        bus_ctrl = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
        bus_addr = AW'($urandom_range(0, 15));
      end
      bus_data  = DW'($urandom);
      out_ready = 1'($urandom % 2);
      arm       = ($urandom % 30 == 0);
      if (arm) begin
        trig_addr = AW'($urandom_range(0, 15));
        trig_mask = 16'h000F;
        trig_ctrl = 2'($urandom_range(0, 2));
      end
      reset = (i != 2000);
      step();
    end
    arm = 1'b0;
    reset = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_trace.md
Name: bus_trace

Overview:
Passive logic-analyser block on the CPU system bus (ADDRBUS/CTRLBUS/DATABUS) for the debugging flow. It snoops every bus transaction and records ctrl, address, data and timestamp into a circular buffer. It stops after a programmable address/ctrl trigger plus a post-trigger count. The captured window is then drained oldest-first over a valid/ready port, for example to a UART dumper or a testbench.

Parameters:
DEPTH, 16, buffer entries; power of two, minimum 4
AW, 16, bus address width
DW, 16, bus data width
TSW, 16, timestamp width
POST, 8, entries captured after the trigger entry; legal range 0..DEPTH-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
bus_addr  in  AW  snooped ADDRBUS
bus_ctrl  in  2  snooped CTRLBUS: 00 none, 01 read, 10 write, 11 reserved
bus_data  in  DW  snooped DATABUS
arm  in  1  single-cycle pulse; clears buffer and starts capture
trig_addr  in  AW  trigger address
trig_mask  in  AW  1 = address bit compared
trig_ctrl  in  2  00 = any read/write, 01 = read only, 10 = write only
out_valid  out  1  drain entry available
out_ready  in  1  drain consumer accepts
out_data  out  2+AW+DW+TSW  {ctrl, addr, data, ts}; MSB first
state  out  2  00 IDLE, 01 ARMED, 10 TRIGGERED, 11 DONE
count  out  clog2(DEPTH)+1  entries held

Behaviour:
- Reset: state IDLE, count 0, pointers 0, timestamp 0, out_valid 0, out_data 0, and all pipeline registers cleared.
  - Reset asserted mid-capture or mid-drain clears everything immediately.
- Timestamp: free-running TSW-bit counter from reset release; wraps modulo 2^TSW.
- Transaction start is detected in cycle t when both hold:
  - bus_ctrl is 01 or 10;
  - bus_ctrl or bus_addr differs from its value at t-1.
  - A transfer held unchanged for several cycles produces one start.
  - 11 and 00 never produce a start.
- Capture pipeline:
  - The start cycle latches ctrl, addr and ts.
  - Write data is bus_data at t.
  - Read data is bus_data at t+1.
  - The entry is written to the buffer at the t+1 edge for both ctrl types.
  - Back-to-back starts every cycle are sustained at one entry per cycle.
- IDLE: no capture. An arm pulse moves to ARMED.
- ARMED and TRIGGERED: captured entries go into the circular buffer.
  - When count = DEPTH, a new write overwrites the oldest entry, the read pointer advances, and count stays DEPTH.
- Trigger, in ARMED only: a start where ((addr ^ trig_addr) & trig_mask) == 0 and (trig_ctrl == 00 or trig_ctrl == ctrl).
  - The trigger entry is stored and the state moves to TRIGGERED.
  - A post-counter then counts POST further entries.
  - With POST=0, the state moves directly to DONE after the trigger entry is written.
- TRIGGERED to DONE: on the cycle the POST-th post-trigger entry is written. Later starts are ignored.
- DONE: out_valid = (count != 0).
  - A handshake (out_valid & out_ready) pops the oldest entry and decrements count.
  - out_data is the entry at the read pointer.
  - out_data is stable while out_valid and not out_ready.
  - out_valid is 0 in every state other than DONE.
- arm is honoured only in IDLE or DONE. It clears count and pointers and moves to ARMED, discarding undrained entries.
  - arm in ARMED or TRIGGERED is ignored.
  - arm in the same cycle as a handshake: arm wins and the pop is discarded.
- A trigger-matching start while TRIGGERED does not retrigger.
- A start in the cycle arm is accepted is not captured. Capture begins with starts on the next cycle.

Decomposition:
- Shared package holds:
  - bus ctrl encodings (CTRL_NONE, CTRL_READ, CTRL_WRITE, CTRL_RSVD);
  - trace state encodings;
  - the entry field offsets within out_data.
- One natural sub-module, trace_ram: DEPTH x (2+AW+DW+TSW) simple dual-port RAM with one write port and an asynchronous read port.
- Pointer, count and FSM logic stays in bus_trace.

Test Plan:
- Reset values: hold reset low, drive bus activity. Expect state 00, count 0, out_valid 0, out_data 0. After release, expect no capture until arm.
- Basic window: arm with trig_addr 0x8000, mask 0xFFFF, ctrl 00, POST 8. Issue 4 writes, then a write to 0x8000, then 8 more writes. Expect state DONE and count 13. The drain returns all 13 in issue order; the 5th entry has addr 0x8000, ctrl 10, and ascending timestamps.
- Pre-trigger wrap: DEPTH 16, POST 8, 30 writes before the trigger. Expect count 16; the first drained entry is pre-trigger write #24 and the last is post #8.
- Read latency: a read to 0x0010 with bus_data 0xABCD one cycle after the start. Expect the entry {01, 0x0010, 0xABCD}. A write in the same test must capture data from its own start cycle.
- Start filtering: ctrl 10 at addr 0x0004 held 3 cycles, followed by ctrl 11 for 2 cycles. Expect exactly one entry. Ctrl 10 then ctrl 01 at the same address gives two entries.
- Drain backpressure and reset: in DONE with out_ready low for 5 cycles, out_data must be stable. Toggle out_ready and confirm one pop per handshake. Assert reset mid-drain; out_valid and count must drop to 0 immediately.
